// File: rtl/fwrisc_regfile_warb_if.sv
// Write-port bundle between the three writeback requesters, the arbiter and the register file.
// The forwarding signals are only meaningful when the arbiter is built with FWRISC_WARB_FWD_EN.
interface fwrisc_regfile_warb_if;
    logic        mem_req;
    logic [5:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        exec_req;
    logic [5:0]  exec_waddr;
    logic [31:0] exec_wdata;
    logic        exec_gnt;
    logic        dbg_req;
    logic [5:0]  dbg_waddr;
    logic [31:0] dbg_wdata;
    logic        dbg_gnt;
    logic [5:0]  rd_waddr;
    logic [31:0] rd_wdata;
    logic        rd_wen;
    logic        drop_pulse;
    logic        busy;
    logic [5:0]  fwd_ra_addr;
    logic [5:0]  fwd_rb_addr;
    logic        fwd_ra_hit;
    logic        fwd_rb_hit;
    logic [31:0] fwd_data;

    modport slave (
        input  mem_req, mem_waddr, mem_wdata,
        input  exec_req, exec_waddr, exec_wdata,
        input  dbg_req, dbg_waddr, dbg_wdata,
        input  fwd_ra_addr, fwd_rb_addr,
        output mem_gnt, exec_gnt, dbg_gnt,
        output rd_waddr, rd_wdata, rd_wen, drop_pulse, busy,
        output fwd_ra_hit, fwd_rb_hit, fwd_data
    );

    modport master (
        output mem_req, mem_waddr, mem_wdata,
        output exec_req, exec_waddr, exec_wdata,
        output dbg_req, dbg_waddr, dbg_wdata,
        output fwd_ra_addr, fwd_rb_addr,
        input  mem_gnt, exec_gnt, dbg_gnt,
        input  rd_waddr, rd_wdata, rd_wen, drop_pulse, busy,
        input  fwd_ra_hit, fwd_rb_hit, fwd_data
    );
endinterface

// File: rtl/fwrisc_regfile_warb.sv
// Register-file write-port arbiter: mem > exec > dbg, with dbg promoted after STARVE_LIMIT waits.
// Optional write-to-read forwarding compare is enabled by defining FWRISC_WARB_FWD_EN.
module fwrisc_regfile_warb #(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter bit          DROP_R0      = 1'b1
) (
    input  logic                        clock,
    input  logic                        reset,
    fwrisc_regfile_warb_if.slave        wb_io
);
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {SEL_NONE, SEL_MEM, SEL_EXEC, SEL_DBG} sel_e;

    sel_e        sel;
    logic        starved;
    logic        is_r0;
    logic [5:0]  sel_addr;
    logic [31:0] sel_data;
    logic [7:0]  dbg_wait_q, dbg_wait_d;
    logic        rd_wen_q, rd_wen_d;
    logic        drop_q, drop_d;
    logic [5:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rd_wen;

    always_comb begin
        sel     = SEL_NONE;
        starved = wb_io.dbg_req && (dbg_wait_q == LIMIT);
        if (!reset) begin
            if (starved)             sel = SEL_DBG;
            else if (wb_io.mem_req)  sel = SEL_MEM;
            else if (wb_io.exec_req) sel = SEL_EXEC;
            else if (wb_io.dbg_req)  sel = SEL_DBG;
        end
    end

    assign wb_io.mem_gnt  = (sel == SEL_MEM);
    assign wb_io.exec_gnt = (sel == SEL_EXEC);
    assign wb_io.dbg_gnt  = (sel == SEL_DBG);

    always_comb begin
        sel_addr = 6'd0;
        sel_data = 32'd0;
        case (sel)
            SEL_MEM:  begin sel_addr = wb_io.mem_waddr;  sel_data = wb_io.mem_wdata;  end
            SEL_EXEC: begin sel_addr = wb_io.exec_waddr; sel_data = wb_io.exec_wdata; end
            SEL_DBG:  begin sel_addr = wb_io.dbg_waddr;  sel_data = wb_io.dbg_wdata;  end
            default:  ;
        endcase
    end

    // A granted r0 write is still consumed from the requester; it just never reaches the file.
    always_comb begin
        is_r0      = DROP_R0 && (sel_addr == 6'd0);
        rd_wen_d   = (sel != SEL_NONE) && !is_r0;
        drop_d     = (sel != SEL_NONE) && is_r0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        dbg_wait_d = dbg_wait_q;
        if (sel != SEL_NONE) begin
            waddr_d = sel_addr;
            wdata_d = sel_data;
        end
        if (!wb_io.dbg_req || (sel == SEL_DBG)) dbg_wait_d = 8'd0;
        else if (dbg_wait_q != LIMIT)           dbg_wait_d = dbg_wait_q + 8'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_wen_q   <= 1'b0;
            drop_q     <= 1'b0;
            waddr_q    <= 6'd0;
            wdata_q    <= 32'd0;
            dbg_wait_q <= 8'd0;
        end else begin
            rd_wen_q   <= rd_wen_d;
            drop_q     <= drop_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            dbg_wait_q <= dbg_wait_d;
        end
    end

    // Gating with reset discards a write that was granted just before reset arrived.
    assign rd_wen           = rd_wen_q & ~reset;
    assign wb_io.rd_wen     = rd_wen;
    assign wb_io.drop_pulse = drop_q & ~reset;
    assign wb_io.rd_waddr   = waddr_q;
    assign wb_io.rd_wdata   = wdata_q;
    assign wb_io.busy       = wb_io.mem_req | wb_io.exec_req | wb_io.dbg_req | rd_wen;

`ifdef FWRISC_WARB_FWD_EN
    assign wb_io.fwd_ra_hit = rd_wen && (waddr_q == wb_io.fwd_ra_addr) && (waddr_q != 6'd0);
    assign wb_io.fwd_rb_hit = rd_wen && (waddr_q == wb_io.fwd_rb_addr) && (waddr_q != 6'd0);
    assign wb_io.fwd_data   = wdata_q;
`else
    assign wb_io.fwd_ra_hit = 1'b0;
    assign wb_io.fwd_rb_hit = 1'b0;
    assign wb_io.fwd_data   = 32'd0;
`endif
endmodule

// File: doc/fwrisc_regfile_warb.md
Name: fwrisc_regfile_warb

Overview:
- Write-port arbiter and sequencer for the single register-file/CSR write port (rd_waddr/rd_wdata/rd_wen).
- Shares the port between three requesters: load writeback from the memory unit (mem), execute-stage writeback (exec), and the debug module (dbg).
- Grants at most one requester per cycle and registers the winning write into a one-stage output register that drives the register file.
- Sits between the core's writeback paths and the register file.

Parameters:
- STARVE_LIMIT, 8: cycles dbg may wait while requesting before it takes top priority; legal range 1..255.
- DROP_R0, 1: 1 = a granted write to address 0 is consumed but rd_wen is not asserted.

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high
- mem_req  in  1  load writeback request; held with addr/data stable until granted
- mem_waddr  in  6  register/CSR address
- mem_wdata  in  32  write data
- mem_gnt  out  1  grant (combinational, same cycle as selection)
- exec_req/exec_waddr/exec_wdata/exec_gnt  in/in/in/out  1/6/32/1  same contract for execute writeback
- dbg_req/dbg_waddr/dbg_wdata/dbg_gnt  in/in/in/out  1/6/32/1  same contract for debug writes
- rd_waddr  out  6  to register file
- rd_wdata  out  32  to register file
- rd_wen  out  1  to register file
- drop_pulse  out  1  one-cycle pulse: a granted write was dropped (r0)
- busy  out  1  any req pending or rd_wen high
- fwd_ra_addr  in  6  forwarding compare address (feature only)
- fwd_rb_addr  in  6  forwarding compare address (feature only)
- fwd_ra_hit  out  1  forwarding hit (feature only)
- fwd_rb_hit  out  1  forwarding hit (feature only)
- fwd_data  out  32  forwarded data (feature only)

Behaviour:
- Reset values: rd_wen=0, rd_waddr=0, rd_wdata=0, drop_pulse=0, starvation counter=0. All gnt outputs are forced 0 while reset is high.
- Priority, normal: mem > exec > dbg.
- Priority, starved: when dbg_wait_cnt == STARVE_LIMIT and dbg_req=1, the order is dbg > mem > exec for that cycle.
- dbg_wait_cnt (8 bit):
  - increments when dbg_req && !dbg_gnt;
  - saturates at STARVE_LIMIT;
  - clears when dbg_gnt=1 or dbg_req=0.
- Handshake:
  - gnt is high only in a cycle where the matching req is high.
  - The requester deasserts req or presents a new write the cycle after gnt.
  - Back-to-back grants to the same requester are allowed.
- Latency: a write granted in cycle N produces rd_wen=1 with that addr/data in cycle N+1; the register file commits at the end of N+1.
- Output register is reloaded every cycle. With no grant, rd_wen=0 next cycle; rd_waddr/rd_wdata hold their previous values.
- r0 drop: if DROP_R0=1 and the granted waddr==0, the request is still granted, rd_wen=0 next cycle, and drop_pulse=1 in N+1. If DROP_R0=0, the write passes through.
- CSR addresses (0x20-0x3F) pass through unmodified. Lock-out and read-only filtering belong to the register file.
- Simultaneous requests: exactly one gnt is high. Losers stay pending with no data loss.
- busy = mem_req | exec_req | dbg_req | rd_wen.
- Reset mid-operation: a pending output write is discarded (rd_wen=0 in the cycle after reset). Requests seen during reset are not granted.

Optional Feature:
- Macro: FWRISC_WARB_FWD_EN.
- When defined:
  - fwd_ra_hit = rd_wen && rd_waddr==fwd_ra_addr && rd_waddr!=0;
  - fwd_rb_hit uses the same rule with fwd_rb_addr;
  - fwd_data = rd_wdata (combinational). This lets read-ports bypass the write committing this cycle.
- When undefined: fwd_ra_hit=0, fwd_rb_hit=0 and fwd_data=0 constantly, and the fwd_*_addr inputs are ignored.

Test Plan:
- Single exec write: exec_req, waddr=5, wdata=0xDEADBEEF in cycle 10 -> exec_gnt=1 in cycle 10; rd_wen=1, rd_waddr=5, rd_wdata=0xDEADBEEF in cycle 11; rd_wen=0 in cycle 12.
- All three requesting in the same cycle -> grant order mem, exec, dbg over three consecutive cycles; rd_wen high for three consecutive cycles with the matching data.
- Starvation: STARVE_LIMIT=4, dbg_req held while mem and exec request continuously -> dbg_gnt in the 5th cycle of dbg_req; counter returns to 0 the next cycle.
- r0 drop: exec writes addr 0, data 0x1234 -> exec_gnt=1, rd_wen=0 next cycle, drop_pulse=1 for exactly one cycle. Repeat with DROP_R0=0 -> rd_wen=1.
- Reset mid-operation: grant mem write in cycle N, assert reset in N+1 -> rd_wen=0 in N+1 and N+2; no gnt during reset; counter=0.
- FWRISC_WARB_FWD_EN defined: grant write addr 7, data 0xA5A5A5A5 with fwd_ra_addr=7, fwd_rb_addr=8 -> in the next cycle fwd_ra_hit=1, fwd_rb_hit=0, fwd_data=0xA5A5A5A5. Undefined build -> all fwd outputs 0.
